saturn_mailbox: RTL and testbench

- Avalon-MM 16-bit slave sitting directly downstream of the Saturn ABUS bus master.
- Consumes its avm_addr/avm_rd/avm_wr/avm_wdata requests and produces avm_rdata/avm_rdvalid/avm_wait.
- Implements a bidirectional mailbox between the Saturn CPU and the on-board MCU: a TX FIFO (Saturn->MCU), an RX FIFO (MCU->Saturn), a status register and a doorbell/control register.
- The MCU side is a pair of valid/ready streams plus an interrupt line.

---
 rtl/saturn_mailbox_pkg.sv | 17 +
 rtl/saturn_mailbox_fifo.sv | 52 +++++
 rtl/saturn_mailbox.sv | 102 ++++++++++
 tb/tb_saturn_mailbox.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/saturn_mailbox_pkg.sv
// saturn_mailbox_pkg: register offsets, STATUS/CTRL bit indices and data width
// shared by the Saturn<->MCU mailbox.
package saturn_mailbox_pkg;
    localparam int DATA_W = 16;
    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_TXDATA = 3'd1;
    localparam logic [2:0] REG_RXDATA = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_DOORBELL = 4;
    localparam int CTRL_DB_SET = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_DB_CLR = 2;
endpackage

// File: rtl/saturn_mailbox_fifo.sv
// mailbox_fifo: show-ahead FIFO with wrap-bit pointers and synchronous flush.
// Ports: clk_i, rst_ni (sync active-low), push_i/data_i write side,
// pop_i/data_o read side (data_o is the head word), flush_i empties the FIFO,
// full_o/empty_o/count_o occupancy.
module mailbox_fifo
    import saturn_mailbox_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [DATA_W-1:0]     data_i,
    output logic [DATA_W-1:0]     data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);
    logic [DATA_W-1:0]   mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic                do_push, do_pop;

    assign full_o  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                     (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
    assign empty_o = wptr_q == rptr_q;
    assign count_o = wptr_q - rptr_q;
    assign data_o  = mem_q[rptr_q[DEPTH_LOG2-1:0]];
    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign do_push = push_i && (!full_o || pop_i) && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wptr_d = flush_i ? '0 : wptr_q + (DEPTH_LOG2+1)'(do_push);
        rptr_d = flush_i ? '0 : rptr_q + (DEPTH_LOG2+1)'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= data_i;
    end
endmodule

// File: rtl/saturn_mailbox.sv
// saturn_mailbox: Avalon-MM 16-bit slave implementing a TX/RX mailbox between
// the Saturn CPU and the MCU.
// Ports: avm_clk/avm_reset_n (sync active-low); avm_addr/avm_rd/avm_wr/avm_wdata
// bus requests; avm_rdata/avm_rdvalid registered read response; avm_wait
// combinational stall; tx_* stream to the MCU; rx_* stream from the MCU;
// mcu_irq mirrors the doorbell.
module saturn_mailbox
    import saturn_mailbox_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic              avm_clk,
    input  logic              avm_reset_n,
    input  logic [31:0]       avm_addr,
    input  logic              avm_rd,
    input  logic              avm_wr,
    input  logic [DATA_W-1:0] avm_wdata,
    output logic [DATA_W-1:0] avm_rdata,
    output logic              avm_rdvalid,
    output logic              avm_wait,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mcu_irq
);
    logic [DATA_W-1:0]   rdata_q, rdata_d, rd_word, status, rx_head;
    logic                rdvalid_q, doorbell_q, doorbell_d;
    logic                in_win, sel_tx, sel_rx, sel_ctrl, wr_only, rd_acc, wr_acc;
    logic                flush, tx_push, tx_pop, rx_push, rx_pop, db_set, db_clr;
    logic                tx_full, tx_empty, rx_full, rx_empty;
    logic [DEPTH_LOG2:0] tx_count, rx_count;
    logic [2:0]          off;
    logic                unused_addr0;

    assign unused_addr0 = avm_addr[0];
    assign in_win   = avm_addr[31:4] == BASE_ADDR[31:4];
    assign off      = avm_addr[3:1];
    assign sel_tx   = in_win && off == REG_TXDATA;
    assign sel_rx   = in_win && off == REG_RXDATA;
    assign sel_ctrl = in_win && off == REG_CTRL;
    // A simultaneous read and write is treated as a read only.
    assign wr_only  = avm_wr && !avm_rd;
    assign avm_wait = (avm_rd && sel_rx && rx_empty) || (wr_only && sel_tx && tx_full);
    assign rd_acc   = avm_rd && !avm_wait;
    assign wr_acc   = wr_only && !avm_wait;

    assign flush    = wr_acc && sel_ctrl && avm_wdata[CTRL_FLUSH];
    assign tx_push  = wr_acc && sel_tx;
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_valid = !tx_empty;
    assign rx_pop   = rd_acc && sel_rx;
    // A full RX FIFO still takes a word when the bus pops the head this cycle.
    assign rx_ready = !rx_full || rx_pop;
    assign rx_push  = rx_valid && rx_ready;

    assign db_set = wr_acc && sel_ctrl && avm_wdata[CTRL_DB_SET];
    assign db_clr = (tx_pop && !flush && !tx_push && tx_count == (DEPTH_LOG2+1)'(1)) ||
                    (wr_acc && sel_ctrl && avm_wdata[CTRL_DB_CLR]);

    assign status = {8'(rx_count), 3'b0, doorbell_q, rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        rd_word    = !in_win              ? '0 :
                     off == REG_STATUS    ? status :
                     off == REG_RXDATA    ? rx_head :
                     off == REG_CTRL      ? {{(DATA_W-1){1'b0}}, doorbell_q} : '0;
        rdata_d    = rd_acc ? rd_word : rdata_q;
        doorbell_d = db_set || (doorbell_q && !db_clr);
    end

    always_ff @(posedge avm_clk) begin
        if (!avm_reset_n) begin
            rdata_q    <= '0;
            rdvalid_q  <= 1'b0;
            doorbell_q <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            rdvalid_q  <= rd_acc;
            doorbell_q <= doorbell_d;
        end
    end

    assign avm_rdata   = rdata_q;
    assign avm_rdvalid = rdvalid_q;
    assign mcu_irq     = doorbell_q;

    mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx (
        .clk_i(avm_clk), .rst_ni(avm_reset_n), .push_i(tx_push), .pop_i(tx_pop),
        .flush_i(flush), .data_i(avm_wdata), .data_o(tx_data), .full_o(tx_full),
        .empty_o(tx_empty), .count_o(tx_count)
    );

    mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx (
        .clk_i(avm_clk), .rst_ni(avm_reset_n), .push_i(rx_push), .pop_i(rx_pop),
        .flush_i(flush), .data_i(rx_data), .data_o(rx_head), .full_o(rx_full),
        .empty_o(rx_empty), .count_o(rx_count)
    );
endmodule

// File: tb/tb_saturn_mailbox.sv
// tb_saturn_mailbox: self-checking bench for saturn_mailbox with a read-data
// scoreboard, a TX-word scoreboard, a register vector table and hand-written
// stall/flush/doorbell/reset sequences.
module tb_saturn_mailbox;
    logic        clk = 1'b0;
    logic        avm_reset_n, avm_rd, avm_wr, avm_rdvalid, avm_wait;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, mcu_irq;
    logic [31:0] avm_addr;
    logic [15:0] avm_wdata, avm_rdata, tx_data, rx_data;
    int          checks = 0, errors = 0;
    logic [15:0] exp_q[$];
    string       nm_q[$];
    logic [15:0] tx_q[$];

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [15:0] wdata;
        logic [15:0] exp;
        string       nm;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    saturn_mailbox dut (
        .avm_clk(clk), .avm_reset_n(avm_reset_n), .avm_addr(avm_addr), .avm_rd(avm_rd),
        .avm_wr(avm_wr), .avm_wdata(avm_wdata), .avm_rdata(avm_rdata),
        .avm_rdvalid(avm_rdvalid), .avm_wait(avm_wait), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mcu_irq(mcu_irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Read-data scoreboard: every accepted read queued an expected word.
    always @(negedge clk) begin
        if (avm_rdvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdvalid: got rdata %h expected no response", avm_rdata);
            end else begin
                chk(nm_q.pop_front(), {16'h0, avm_rdata}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_accept(input string nm, output bit ok);
        int n = 0;
        #1;
        while (avm_wait && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = !avm_wait;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got wait=1 expected acceptance", nm);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [15:0] exp, input string nm);
        bit ok;
        avm_addr = a;
        avm_rd   = 1'b1;
        avm_wr   = 1'b0;
        wait_accept(nm, ok);
        if (ok) begin
            exp_q.push_back(exp);
            nm_q.push_back(nm);
        end
        @(negedge clk);
        avm_rd = 1'b0;
        if (ok) chk({nm, "_rdvalid"}, {31'h0, avm_rdvalid}, 32'h1);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [15:0] d);
        bit ok;
        avm_addr  = a;
        avm_wdata = d;
        avm_wr    = 1'b1;
        avm_rd    = 1'b0;
        wait_accept("write", ok);
        if (ok && a[31:4] == 28'h0 && a[3:1] == 3'd1) tx_q.push_back(d);
        if (ok && a[31:4] == 28'h0 && a[3:1] == 3'd3 && d[1]) tx_q.delete();
        @(negedge clk);
        avm_wr = 1'b0;
    endtask

    task automatic tx_pop(input string nm);
        chk({nm, "_txvalid"}, {31'h0, tx_valid}, 32'h1);
        if (tx_q.size() != 0) chk({nm, "_txdata"}, {16'h0, tx_data}, {16'h0, tx_q.pop_front()});
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic rx_push(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = base + 16'(i);
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        avm_reset_n = 1'b0; avm_rd = 1'b0; avm_wr = 1'b0; avm_addr = '0; avm_wdata = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        vecs = '{
            '{32'h0, 1'b1, 16'h0000, 16'h000A, "status_reset"},
            '{32'h6, 1'b0, 16'h0001, 16'h0000, "ctrl_set"},
            '{32'h6, 1'b1, 16'h0000, 16'h0001, "ctrl_db1"},
            '{32'h0, 1'b1, 16'h0000, 16'h001A, "status_db"},
            '{32'h6, 1'b0, 16'h0004, 16'h0000, "ctrl_clr"},
            '{32'h6, 1'b1, 16'h0000, 16'h0000, "ctrl_db0"},
            '{32'h6, 1'b0, 16'h0005, 16'h0000, "ctrl_set_clr"},
            '{32'h6, 1'b1, 16'h0000, 16'h0001, "ctrl_set_wins"},
            '{32'h6, 1'b0, 16'h0004, 16'h0000, "ctrl_clr2"},
            '{32'hA, 1'b0, 16'hFFFF, 16'h0000, "wr_off5"},
            '{32'h8, 1'b1, 16'h0000, 16'h0000, "rd_off4"},
            '{32'hE, 1'b1, 16'h0000, 16'h0000, "rd_off7"},
            '{32'h42, 1'b0, 16'hDEAD, 16'h0000, "wr_outside"},
            '{32'h40, 1'b1, 16'h0000, 16'h0000, "rd_outside"},
            '{32'h0, 1'b1, 16'h0000, 16'h000A, "status_after_outside"},
            '{32'h2, 1'b0, 16'h1234, 16'h0000, "tx_one"},
            '{32'h0, 1'b1, 16'h0000, 16'h0008, "status_tx1"},
            '{32'h6, 1'b0, 16'h0002, 16'h0000, "flush"},
            '{32'h0, 1'b1, 16'h0000, 16'h000A, "status_flushed"}
        };
        repeat (3) @(negedge clk);
        chk("reset_rdvalid", {31'h0, avm_rdvalid}, 32'h0);
        chk("reset_rdata", {16'h0, avm_rdata}, 32'h0);
        avm_reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_irq", {31'h0, mcu_irq}, 32'h0);
        chk("reset_txvalid", {31'h0, tx_valid}, 32'h0);
        chk("reset_rxready", {31'h0, rx_ready}, 32'h1);
        chk("reset_wait", {31'h0, avm_wait}, 32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].rd) bus_read(vecs[i].addr, vecs[i].exp, vecs[i].nm);
            else bus_write(vecs[i].addr, vecs[i].wdata);
        end
        chk("tx_valid_after_flush", {31'h0, tx_valid}, 32'h0);

        for (int i = 0; i < 16; i++) bus_write(32'h2, 16'h1000 + 16'(i));
        bus_read(32'h0, 16'h0009, "status_tx_full");
        avm_addr = 32'h2; avm_wdata = 16'h2000; avm_wr = 1'b1;
        #1;
        chk("tx_full_wait", {31'h0, avm_wait}, 32'h1);
        repeat (3) @(negedge clk);
        #1;
        chk("tx_full_wait_held", {31'h0, avm_wait}, 32'h1);
        tx_pop("tx_head");
        #1;
        chk("tx_wait_release", {31'h0, avm_wait}, 32'h0);
        tx_q.push_back(16'h2000);
        @(negedge clk);
        avm_wr = 1'b0;
        bus_read(32'h0, 16'h0009, "status_tx_refull");
        for (int i = 0; i < 16; i++) tx_pop("tx_drain");
        chk("tx_drained", {31'h0, tx_valid}, 32'h0);

        avm_addr = 32'h4; avm_rd = 1'b1;
        #1;
        chk("rx_empty_wait", {31'h0, avm_wait}, 32'h1);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 16'hBEEF;
        #1;
        chk("rx_wait_during_push", {31'h0, avm_wait}, 32'h1);
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        chk("rx_wait_release", {31'h0, avm_wait}, 32'h0);
        exp_q.push_back(16'hBEEF); nm_q.push_back("rx_beef");
        @(negedge clk);
        avm_rd = 1'b0;
        chk("rx_beef_rdvalid", {31'h0, avm_rdvalid}, 32'h1);
        @(negedge clk);
        chk("rdvalid_one_cycle", {31'h0, avm_rdvalid}, 32'h0);

        rx_push(3, 16'h0011);
        bus_read(32'h0, 16'h0302, "status_rx3");
        bus_read(32'h4, 16'h0011, "rx_order");
        rx_valid = 1'b1; rx_data = 16'h7777;
        bus_write(32'h6, 16'h0002);
        rx_valid = 1'b0;
        bus_read(32'h0, 16'h000A, "status_flush_rx");

        rx_push(16, 16'h3000);
        #1;
        chk("rx_full_ready", {31'h0, rx_ready}, 32'h0);
        avm_addr = 32'h4; avm_rd = 1'b1; rx_valid = 1'b1; rx_data = 16'h4000;
        #1;
        chk("rx_full_pop_ready", {31'h0, rx_ready}, 32'h1);
        exp_q.push_back(16'h3000); nm_q.push_back("rx_full_head");
        @(negedge clk);
        avm_rd = 1'b0; rx_valid = 1'b0;
        bus_read(32'h0, 16'h1006, "status_rx_full_kept");
        bus_write(32'h6, 16'h0002);

        bus_write(32'h6, 16'h0001);
        chk("irq_set", {31'h0, mcu_irq}, 32'h1);
        bus_write(32'h2, 16'h5555);
        tx_pop("db_pop");
        chk("irq_cleared_by_pop", {31'h0, mcu_irq}, 32'h0);
        bus_write(32'h2, 16'h6666);
        chk("db_last_word", {16'h0, tx_data}, {16'h0, tx_q.pop_front()});
        tx_ready = 1'b1;
        bus_write(32'h6, 16'h0001);
        tx_ready = 1'b0;
        chk("irq_set_wins_pop", {31'h0, mcu_irq}, 32'h1);
        chk("db_popped", {31'h0, tx_valid}, 32'h0);
        bus_write(32'h6, 16'h0004);
        chk("irq_ctrl_clr", {31'h0, mcu_irq}, 32'h0);

        for (int i = 0; i < 16; i++) bus_write(32'h2, 16'h8000 + 16'(i));
        bus_write(32'h6, 16'h0001);
        bus_read(32'h0, 16'h0019, "status_pre_reset");
        avm_addr = 32'h2; avm_wdata = 16'h9999; avm_wr = 1'b1;
        #1;
        chk("stall_before_reset", {31'h0, avm_wait}, 32'h1);
        avm_reset_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_reset_rdata", {16'h0, avm_rdata}, 32'h0);
        chk("mid_reset_rdvalid", {31'h0, avm_rdvalid}, 32'h0);
        chk("mid_reset_irq", {31'h0, mcu_irq}, 32'h0);
        chk("mid_reset_txvalid", {31'h0, tx_valid}, 32'h0);
        chk("mid_reset_rxready", {31'h0, rx_ready}, 32'h1);
        chk("mid_reset_wait", {31'h0, avm_wait}, 32'h0);
        avm_wr = 1'b0; avm_reset_n = 1'b1; tx_q.delete();
        @(negedge clk);
        bus_write(32'h2, 16'hABCD);
        tx_pop("retry_after_reset");

        avm_addr = 32'h0; avm_rd = 1'b1; avm_reset_n = 1'b0;
        @(negedge clk);
        avm_rd = 1'b0; avm_reset_n = 1'b1;
        chk("rdvalid_suppressed", {31'h0, avm_rdvalid}, 32'h0);
        @(negedge clk);
        bus_read(32'h0, 16'h000A, "status_final");

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
